// File: rtl/canv_pkg.sv
// Shared canvas definitions: widths, pixel-depth shift codes and the
// span writer's state encoding.
package canv_pkg;

  localparam int CORDW  = 16;  // signed coordinate width
  localparam int WORD   = 32;  // vram word width
  localparam int ADDRW  = 14;  // vram word address width
  localparam int SHIFTW = 3;   // width of addr_shift
  localparam int CIDXW  = 8;   // colour index width
  localparam int PIXW   = 5;   // pixel index within a word, log2(WORD)

  // addr_shift codes: log2 of pixels per word
  localparam logic [SHIFTW-1:0] SHIFT_1BPP = 3'd5;
  localparam logic [SHIFTW-1:0] SHIFT_2BPP = 3'd4;
  localparam logic [SHIFTW-1:0] SHIFT_4BPP = 3'd3;
  localparam logic [SHIFTW-1:0] SHIFT_8BPP = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SPAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/canv_pix_mask.sv
// Maps a pixel position inside a vram word to its bit mask, and a colour
// index to a word with that index replicated into every pixel slot.
module canv_pix_mask
  import canv_pkg::*;
(
  input  logic [PIXW-1:0]   pix_id,
  input  logic [SHIFTW-1:0] addr_shift,
  input  logic [CIDXW-1:0]  cidx,
  output logic [WORD-1:0]   mask,
  output logic [WORD-1:0]   data
);

  logic [5:0]      bpp;
  logic [WORD-1:0] ones;
  logic [10:0]     bit_pos;

  // pixel mask: bpp ones shifted to the pixel's slot
  always_comb begin
    bpp     = 6'(WORD >> addr_shift);
    ones    = {WORD{1'b1}} >> (6'd32 - bpp);
    bit_pos = 11'(pix_id) * 11'(bpp);
    mask    = ones << bit_pos;
  end

  // colour index truncated to bpp bits and replicated across the word
  always_comb begin
    case (addr_shift)
      SHIFT_1BPP: data = {32{cidx[0]}};
      SHIFT_2BPP: data = {16{cidx[1:0]}};
      SHIFT_4BPP: data = {8{cidx[3:0]}};
      SHIFT_8BPP: data = {4{cidx}};
      3'd1:       data = {2{8'h00, cidx}};
      3'd0:       data = {24'h000000, cidx};
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/canv_pix_write.sv
// Canvas span writer: clips a horizontal span to the canvas and emits one
// masked vram write per word touched, using the display's base/shift packing.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_SETUP | clip span, register line address
// ST_SPAN  | one pixel per cycle, write on word close
// ST_DONE  | done pulse, back to idle
module canv_pix_write
  import canv_pkg::*;
(
  input  logic                    clk_sys,
  input  logic                    rst_sys,
  input  logic [ADDRW-1:0]        addr_base,
  input  logic [SHIFTW-1:0]       addr_shift,
  input  logic [CORDW-1:0]        canv_width,
  input  logic [CORDW-1:0]        canv_height,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic signed [CORDW-1:0] req_x,
  input  logic signed [CORDW-1:0] req_y,
  input  logic [CORDW-1:0]        req_len,
  input  logic [CIDXW-1:0]        req_cidx,
  output logic                    busy,
  output logic                    done,
  output logic [WORD-1:0]         vram_wmask,
  output logic [ADDRW-1:0]        vram_addr,
  output logic [WORD-1:0]         vram_din
);

  state_t                  state;
  logic signed [CORDW-1:0] lat_x, lat_y;
  logic [CORDW-1:0]        lat_len;
  logic [CIDXW-1:0]        lat_cidx;
  logic signed [CORDW:0]   cur_x, end_x;
  logic [ADDRW-1:0]        line_addr;
  logic [WORD-1:0]         mask_acc;

  logic signed [CORDW:0] x_ext, y_ext, x_sum, width_ext, height_ext;
  logic signed [CORDW:0] clip_x0, clip_x1;
  logic [CORDW-1:0]      stride;
  logic [ADDRW-1:0]      line_prod;
  logic                  skip;

  logic [CORDW-1:0] cur_u, nxt_u, word, nxt_word;
  logic [5:0]       pix_sel;
  logic [PIXW-1:0]  pix_id;
  logic             last, close;
  logic [WORD-1:0]  pix_mask, pix_data, new_mask;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // clipping and line address for the latched request (one extra sign bit)
  always_comb begin
    x_ext      = {lat_x[CORDW-1], lat_x};
    y_ext      = {lat_y[CORDW-1], lat_y};
    width_ext  = {1'b0, canv_width};
    height_ext = {1'b0, canv_height};
    x_sum      = x_ext + $signed({1'b0, lat_len});
    clip_x0    = x_ext[CORDW] ? '0 : x_ext;
    clip_x1    = (x_sum < width_ext) ? x_sum : width_ext;
    stride     = canv_width >> addr_shift;
    // low product bits only depend on low operand bits, so the wrap is exact
    line_prod  = lat_y[ADDRW-1:0] * stride[ADDRW-1:0];
    skip       = y_ext[CORDW] || (y_ext >= height_ext) ||
                 (clip_x0 >= clip_x1) || (lat_len == '0);
  end

  // per-pixel word/slot decode and word-close detection
  always_comb begin
    cur_u    = cur_x[CORDW-1:0];
    nxt_u    = cur_u + 1'b1;
    word     = cur_u >> addr_shift;
    nxt_word = nxt_u >> addr_shift;
    pix_sel  = (6'd1 << addr_shift) - 6'd1;
    pix_id   = cur_u[PIXW-1:0] & pix_sel[PIXW-1:0];
    last     = ($signed({1'b0, nxt_u}) == end_x);
    close    = last || (nxt_word != word);
    new_mask = mask_acc | pix_mask;
  end

  canv_pix_mask u_mask (
    .pix_id     (pix_id),
    .addr_shift (addr_shift),
    .cidx       (lat_cidx),
    .mask       (pix_mask),
    .data       (pix_data)
  );

  // request FSM with registered vram outputs and done pulse
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state      <= ST_IDLE;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_len    <= '0;
      lat_cidx   <= '0;
      cur_x      <= '0;
      end_x      <= '0;
      line_addr  <= '0;
      mask_acc   <= '0;
      vram_wmask <= '0;
      vram_addr  <= '0;
      vram_din   <= '0;
      done       <= 1'b0;
    end else begin
      vram_wmask <= '0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_x    <= req_x;
            lat_y    <= req_y;
            lat_len  <= req_len;
            lat_cidx <= req_cidx;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          line_addr <= addr_base + line_prod;
          cur_x     <= clip_x0;
          end_x     <= clip_x1;
          mask_acc  <= '0;
          if (skip) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_SPAN;
          end
        end
        ST_SPAN: begin
          if (close) begin
            vram_wmask <= new_mask;
            vram_addr  <= line_addr + word[ADDRW-1:0];
            vram_din   <= pix_data;
            mask_acc   <= '0;
          end else begin
            mask_acc   <= new_mask;
          end
          if (last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            cur_x <= cur_x + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canv_pix_write.sv
// Directed and randomised span requests against a scoreboard of expected
// vram writes (cycle, address, mask, data) and done latency.
module tb_canv_pix_write;
  import canv_pkg::*;

  logic                    clk_sys = 1'b0;
  logic                    rst_sys = 1'b1;
  logic [ADDRW-1:0]        addr_base = '0;
  logic [SHIFTW-1:0]       addr_shift = 3'd3;
  logic [CORDW-1:0]        canv_width = 16'd320;
  logic [CORDW-1:0]        canv_height = 16'd240;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic signed [CORDW-1:0] req_x = '0;
  logic signed [CORDW-1:0] req_y = '0;
  logic [CORDW-1:0]        req_len = '0;
  logic [CIDXW-1:0]        req_cidx = '0;
  logic                    busy, done;
  logic [WORD-1:0]         vram_wmask;
  logic [ADDRW-1:0]        vram_addr;
  logic [WORD-1:0]         vram_din;

  canv_pix_write dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .addr_base(addr_base),
    .addr_shift(addr_shift), .canv_width(canv_width), .canv_height(canv_height),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_len(req_len), .req_cidx(req_cidx), .busy(busy), .done(done),
    .vram_wmask(vram_wmask), .vram_addr(vram_addr), .vram_din(vram_din)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] mask;
    logic [31:0] din;
  } wr_t;
  wr_t sb[$];
  wr_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // write monitor: every nonzero mask must match the head of the scoreboard
  always @(negedge clk_sys) begin
    if (mon_en && (vram_wmask !== '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_write", vram_wmask, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_cyc", cyc, mon_e.cyc);
        check("wr_addr", 32'(vram_addr), mon_e.addr);
        check("wr_mask", vram_wmask, mon_e.mask);
        check("wr_din", vram_din, mon_e.din);
      end
    end
  end

  task automatic push(input int c, input int a, input logic [31:0] m, input logic [31:0] d);
    wr_t e;
    e.cyc = c; e.addr = 32'(a); e.mask = m; e.din = d;
    sb.push_back(e);
  endtask

  task automatic do_req(input int x, input int y, input int len, input logic [7:0] c,
                        output int acc);
    int guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin
      @(posedge clk_sys); #1; guard++;
    end
    check("ready_before_req", req_ready, 1);
    req_x = CORDW'(x); req_y = CORDW'(y); req_len = CORDW'(len); req_cidx = c;
    req_valid = 1'b1;
    @(posedge clk_sys); #1;
    req_valid = 1'b0;
    acc = cyc;
    req_x = CORDW'($urandom); req_y = CORDW'($urandom);
    req_len = CORDW'($urandom); req_cidx = CIDXW'($urandom);
  endtask

  task automatic wait_done(input int acc, input int lat);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      check("ready_low", req_ready, 0);
      check("busy_high", busy, 1);
      @(posedge clk_sys); #1; n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("done_lat", cyc - acc, lat);
    @(posedge clk_sys); #1;
    check("done_pulse", done, 0);
    check("ready_after", req_ready, 1);
    check("busy_after", busy, 0);
  endtask

  // reference model: pushes expected writes, returns done latency
  task automatic model(input int s, input int w, input int h, input int base,
                       input int x, input int y, input int len, input logic [7:0] c,
                       input int acc, output int lat);
    int x0, x1, bpp, stride, line, wd, pid, n;
    logic [31:0] m, d, cv;
    bpp = 32 >> s;
    stride = w >> s;
    x0 = (x < 0) ? 0 : x;
    x1 = (x + len < w) ? x + len : w;
    if (y < 0 || y >= h || x0 >= x1 || len == 0) begin
      lat = 1;
      return;
    end
    line = (base + y * stride) & 16'h3fff;
    cv = 32'(c);
    if (bpp < 32) cv = cv & ((32'd1 << bpp) - 1);
    for (int i = 0; i < 32; i++) d[i] = cv[i % bpp];
    m = '0;
    n = 0;
    for (int px = x0; px < x1; px++) begin
      wd = px >> s;
      pid = px & ((1 << s) - 1);
      for (int b = 0; b < bpp; b++) m[pid * bpp + b] = 1'b1;
      if (px + 1 == x1 || ((px + 1) >> s) != wd) begin
        push(acc + 2 + n, (line + wd) & 16'h3fff, m, d);
        m = '0;
      end
      n++;
    end
    lat = 1 + n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, s, base, x, y, len;
    logic [7:0] c;

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_wmask", vram_wmask, 0);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_din", vram_din, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    rst_sys = 1'b0;
    mon_en = 1'b1;

    // 4 bpp single pixel
    addr_shift = SHIFT_4BPP; canv_width = 16'd320; addr_base = '0;
    do_req(3, 2, 1, 8'h05, acc);
    push(acc + 2, 80, 32'h0000F000, 32'h55555555);
    wait_done(acc, 2);

    // 4 bpp word-crossing span
    do_req(6, 0, 4, 8'h0A, acc);
    push(acc + 3, 0, 32'hFF000000, 32'hAAAAAAAA);
    push(acc + 5, 1, 32'h000000FF, 32'hAAAAAAAA);
    wait_done(acc, 5);

    // 1 bpp aligned full word
    addr_shift = SHIFT_1BPP;
    do_req(32, 0, 32, 8'h01, acc);
    push(acc + 33, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(acc, 33);

    // 8 bpp clipping
    addr_shift = SHIFT_8BPP;
    do_req(-2, 0, 3, 8'h3C, acc);
    push(acc + 2, 0, 32'h000000FF, 32'h3C3C3C3C);
    wait_done(acc, 2);
    do_req(0, -1, 5, 8'h11, acc);
    wait_done(acc, 1);
    do_req(318, 0, 10, 8'h12, acc);
    push(acc + 3, 79, 32'hFFFF0000, 32'h12121212);
    wait_done(acc, 3);
    do_req(5, 0, 0, 8'h12, acc);
    wait_done(acc, 1);
    do_req(0, 240, 4, 8'h12, acc);
    wait_done(acc, 1);

    // reset mid-span: first write would land 5 edges after accept
    do_req(0, 1, 16, 8'h77, acc);
    repeat (3) begin @(posedge clk_sys); #1; end
    rst_sys = 1'b1;
    @(posedge clk_sys); #1;
    check("midrst_wmask", vram_wmask, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    rst_sys = 1'b0;
    repeat (20) begin
      @(posedge clk_sys); #1;
      check("midrst_no_done", done, 0);
    end

    // back-to-back requests
    addr_shift = SHIFT_4BPP; addr_base = 14'd100;
    do_req(14, 3, 3, 8'h0C, acc);
    push(acc + 3, 100 + 120 + 1, 32'hFF000000, 32'hCCCCCCCC);
    push(acc + 4, 100 + 120 + 2, 32'h0000000F, 32'hCCCCCCCC);
    wait_done(acc, 4);
    do_req(0, 0, 1, 8'h03, acc);
    push(acc + 2, 100, 32'h0000000F, 32'h33333333);
    wait_done(acc, 2);

    // randomised spans against the model
    for (int t = 0; t < 14; t++) begin
      s = 2 + int'($urandom_range(0, 3));
      base = int'($urandom_range(0, 16383));
      x = int'($urandom_range(0, 380)) - 40;
      y = int'($urandom_range(0, 250)) - 5;
      len = int'($urandom_range(0, 40));
      c = 8'($urandom);
      addr_shift = SHIFTW'(s); addr_base = ADDRW'(base);
      canv_width = 16'd320; canv_height = 16'd240;
      do_req(x, y, len, c, acc);
      model(s, 320, 240, base, x, y, len, c, acc, lat);
      wait_done(acc, lat);
    end

    repeat (3) @(posedge clk_sys);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
